// File: rtl/vga_fb_writer_if.sv
// Pixel-plot / framebuffer-port bundle for vga_fb_writer.
//   slave  : the writer (consumes pixel requests, drives the RAM write port)
//   master : the environment (plotting FSMs, RAM arbiter)
// Signals: writeEn/x/y/colour pixel request, ClearGo/ClearColour fill request,
// mem_grant RAM port availability, Full/Busy/DroppedCount status,
// mem_address/mem_data/mem_wren RAM write port.
interface vga_fb_writer_if #(
    parameter int unsigned COLOUR_W = 12
);
    logic                writeEn;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                ClearGo;
    logic [COLOUR_W-1:0] ClearColour;
    logic                mem_grant;
    logic                Full;
    logic                Busy;
    logic [14:0]         mem_address;
    logic [COLOUR_W-1:0] mem_data;
    logic                mem_wren;
    logic [7:0]          DroppedCount;

    modport slave (
        input  writeEn, x, y, colour, ClearGo, ClearColour, mem_grant,
        output Full, Busy, mem_address, mem_data, mem_wren, DroppedCount
    );

    modport master (
        output writeEn, x, y, colour, ClearGo, ClearColour, mem_grant,
        input  Full, Busy, mem_address, mem_data, mem_wren, DroppedCount
    );
endinterface

// File: rtl/vga_fb_writer.sv
// Framebuffer writer: queues single-pixel writes in a FIFO and drains them into
// the shared 160x120 framebuffer RAM write port whenever mem_grant allows.
// Also performs a full-screen fill on ClearGo.
// Ports:
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : pixel request, clear request, RAM write port, status
module vga_fb_writer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned H_RES      = 160,
    parameter int unsigned V_RES      = 120,
    parameter int unsigned COLOUR_W   = 12
) (
    input  logic            Clock,
    input  logic            Reset,
    vga_fb_writer_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned ADDR_W = 15;

    localparam logic [7:0]        X_LIM    = 8'(H_RES);
    localparam logic [6:0]        Y_LIM    = 7'(V_RES);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_RES * V_RES - 1);

    typedef struct packed {
        logic [7:0]          x;
        logic [6:0]          y;
        logic [COLOUR_W-1:0] colour;
    } pix_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_CLEAR
    } state_t;

    state_t              state_q, state_d;
    pix_t                fifo_q [FIFO_DEPTH];
    pix_t                fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [COLOUR_W-1:0] clr_colour_q, clr_colour_d;
    logic                mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [COLOUR_W-1:0] mem_data_q, mem_data_d;
    logic [7:0]          dropped_q, dropped_d;

    logic full;
    logic in_range;
    logic push;
    logic pop;
    logic clear_start;
    pix_t head;

    // Next-state, FIFO bookkeeping and RAM port outputs.
    always_comb begin
        state_d       = state_q;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        clr_cnt_d     = clr_cnt_q;
        clr_colour_d  = clr_colour_q;
        mem_wren_d    = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        dropped_d     = dropped_q;

        // Full depends only on the current count, so a same-cycle pop never frees a slot.
        full        = (count_q == CNT_FULL) || (state_q == S_CLEAR);
        in_range    = (bus.x < X_LIM) && (bus.y < Y_LIM);
        push        = bus.writeEn && !full && in_range && !bus.ClearGo;
        clear_start = bus.ClearGo && (state_q != S_CLEAR);
        // A clear request flushes the queue, so nothing is popped in that cycle.
        pop         = (state_q == S_DRAIN) && bus.mem_grant && !clear_start;
        head        = fifo_q[rd_ptr_q];

        if (bus.writeEn && !push && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = '{x: bus.x, y: bus.y, colour: bus.colour};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d      = rd_ptr_q + PTR_W'(1);
            mem_wren_d    = 1'b1;
            // y*160 + x as y*128 + y*32 + x
            mem_address_d = (ADDR_W'(head.y) << 7) + (ADDR_W'(head.y) << 5) + ADDR_W'(head.x);
            mem_data_d    = head.colour;
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (state_q == S_CLEAR && bus.mem_grant) begin
            mem_wren_d    = 1'b1;
            mem_address_d = clr_cnt_q;
            mem_data_d    = clr_colour_q;
            clr_cnt_d     = clr_cnt_q + ADDR_W'(1);
        end

        if (clear_start) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            clr_cnt_d    = '0;
            clr_colour_d = bus.ClearColour;
        end

        if (clear_start) begin
            state_d = S_CLEAR;
        end else if (state_q == S_CLEAR) begin
            if (bus.mem_grant && (clr_cnt_q == CLR_LAST)) begin
                state_d = S_IDLE;
            end
        end else begin
            state_d = (count_d != '0) ? S_DRAIN : S_IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            fifo_q        <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            clr_cnt_q     <= '0;
            clr_colour_q  <= '0;
            mem_wren_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            dropped_q     <= '0;
        end else begin
            state_q       <= state_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            clr_cnt_q     <= clr_cnt_d;
            clr_colour_q  <= clr_colour_d;
            mem_wren_q    <= mem_wren_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            dropped_q     <= dropped_d;
        end
    end

    assign bus.Full         = full;
    assign bus.Busy         = (state_q != S_IDLE) || mem_wren_q;
    assign bus.mem_wren     = mem_wren_q;
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_data     = mem_data_q;
    assign bus.DroppedCount = dropped_q;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Self-checking bench for vga_fb_writer: a per-cycle reference model built on a
// queue of pending writes plus directed sequences and a table of pixel vectors.
module tb_vga_fb_writer;
    localparam int unsigned CW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_fb_writer_if #(.COLOUR_W(CW)) bus ();

    vga_fb_writer #(
        .FIFO_DEPTH (16),
        .H_RES      (160),
        .V_RES      (120),
        .COLOUR_W   (CW)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            addr;
        logic [CW-1:0] col;
    } ment_t;

    ment_t         mq[$];
    ment_t         m_e;
    bit            m_clr  = 1'b0;
    int            m_cnt  = 0;
    logic [CW-1:0] m_ccol = '0;
    bit            m_wren = 1'b0;
    int            m_addr = 0;
    logic [CW-1:0] m_data = '0;
    int            m_drop = 0;
    bit            m_acc, m_full, m_w;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_clr  = 1'b0;
            m_wren = 1'b0;
            m_addr = 0;
            m_data = '0;
            m_drop = 0;
        end else begin
            m_full = (mq.size() == 16) || m_clr;
            m_acc  = bus.writeEn && !m_full && (int'(bus.x) < 160) && (int'(bus.y) < 120) && !bus.ClearGo;
            if (bus.writeEn && !m_acc && m_drop < 255) m_drop++;
            m_w = 1'b0;
            if (m_clr) begin
                if (bus.mem_grant) begin
                    m_w    = 1'b1;
                    m_addr = m_cnt;
                    m_data = m_ccol;
                    m_cnt++;
                    if (m_cnt == 160 * 120) m_clr = 1'b0;
                end
            end else if (bus.ClearGo) begin
                mq.delete();
                m_clr  = 1'b1;
                m_cnt  = 0;
                m_ccol = bus.ClearColour;
            end else if (bus.mem_grant && mq.size() > 0) begin
                m_e    = mq.pop_front();
                m_w    = 1'b1;
                m_addr = m_e.addr;
                m_data = m_e.col;
            end
            if (m_acc) mq.push_back('{int'(bus.y) * 160 + int'(bus.x), bus.colour});
            m_wren = m_w;
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (bus.mem_wren !== m_wren ||
                (m_wren && (bus.mem_address !== 15'(m_addr) || bus.mem_data !== m_data)) ||
                bus.DroppedCount !== 8'(m_drop) ||
                bus.Full !== ((mq.size() == 16) || m_clr) ||
                bus.Busy !== (m_clr || mq.size() > 0 || m_wren)) begin
                n_fail++;
                $display("FAIL model t=%0t: got wren=%0b addr=%0d data=%h drop=%0d full=%0b busy=%0b; expected wren=%0b addr=%0d data=%h drop=%0d full=%0b busy=%0b",
                         $time, bus.mem_wren, bus.mem_address, bus.mem_data, bus.DroppedCount, bus.Full, bus.Busy,
                         m_wren, m_addr, m_data, m_drop, (mq.size() == 16) || m_clr, m_clr || mq.size() > 0 || m_wren);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic setpix(input bit we, input int px, input int py, input logic [CW-1:0] c);
        bus.writeEn = we;
        bus.x       = 8'(px);
        bus.y       = 7'(py);
        bus.colour  = c;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.writeEn = 1'b0;
        bus.ClearGo = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int            px;
        int            py;
        logic [CW-1:0] c;
        bit            acc;
        int            addr;
    } vec_t;

    vec_t vt[8];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_drop;
        int nw;
        int errs;
        int seen;
        bit hit;
        bit g;

        bus.writeEn     = 1'b0;
        bus.x           = '0;
        bus.y           = '0;
        bus.colour      = '0;
        bus.ClearGo     = 1'b0;
        bus.ClearColour = '0;
        bus.mem_grant   = 1'b0;

        vt[0] = '{0,   0,   12'hABC, 1'b1, 0};
        vt[1] = '{159, 0,   12'h111, 1'b1, 159};
        vt[2] = '{0,   119, 12'h222, 1'b1, 19040};
        vt[3] = '{159, 119, 12'h333, 1'b1, 19199};
        vt[4] = '{160, 0,   12'h444, 1'b0, 0};
        vt[5] = '{255, 127, 12'h555, 1'b0, 0};
        vt[6] = '{10,  5,   12'h666, 1'b1, 810};
        vt[7] = '{80,  60,  12'h777, 1'b1, 9680};

        // Reset state
        tick();
        do_reset();
        chk_en = 1'b1;
        chk("rst_wren", bus.mem_wren, 0);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_data", bus.mem_data, 0);
        chk("rst_drop", bus.DroppedCount, 0);
        chk("rst_full", bus.Full, 0);
        chk("rst_busy", bus.Busy, 0);

        // Single write, two-cycle latency
        bus.mem_grant = 1'b1;
        setpix(1, 10, 5, 12'hF00);
        tick();
        setpix(0, 0, 0, 12'h000);
        chk("lat_t1_wren", bus.mem_wren, 0);
        tick();
        chk("lat_t2_wren", bus.mem_wren, 1);
        chk("lat_addr", bus.mem_address, 810);
        chk("lat_data", bus.mem_data, 12'hF00);
        tick();
        chk("lat_busy_after", bus.Busy, 0);

        // Table of pixel vectors
        do_reset();
        exp_drop = 0;
        bus.mem_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            setpix(1, vt[i].px, vt[i].py, vt[i].c);
            tick();
            setpix(0, 0, 0, 12'h000);
            if (!vt[i].acc) exp_drop++;
            tick();
            chk($sformatf("vec%0d_wren", i), bus.mem_wren, vt[i].acc);
            if (vt[i].acc) begin
                chk($sformatf("vec%0d_addr", i), bus.mem_address, vt[i].addr);
                chk($sformatf("vec%0d_data", i), bus.mem_data, vt[i].c);
            end
            chk($sformatf("vec%0d_drop", i), bus.DroppedCount, exp_drop);
            tick();
        end

        // FIFO fill with grant low, 17th request rejected, then drain in order
        do_reset();
        bus.mem_grant = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) chk("fill_full", bus.Full, 1);
            setpix(1, i, i, 12'(i + 1));
            tick();
        end
        setpix(0, 0, 0, 12'h000);
        chk("fill_drop", bus.DroppedCount, 1);
        bus.mem_grant = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 0) chk("drain_full_released", bus.Full, 0);
            chk($sformatf("drain%0d_wren", k), bus.mem_wren, 1);
            chk($sformatf("drain%0d_addr", k), bus.mem_address, k * 161);
            chk($sformatf("drain%0d_data", k), bus.mem_data, k + 1);
        end
        tick();
        chk("drain_end_wren", bus.mem_wren, 0);

        // Out-of-range boundaries
        do_reset();
        bus.mem_grant = 1'b1;
        setpix(1, 160, 0, 12'h0AA);
        tick();
        setpix(1, 0, 120, 12'h0BB);
        tick();
        setpix(1, 159, 119, 12'h0CC);
        tick();
        setpix(0, 0, 0, 12'h000);
        seen = 0;
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.mem_wren) begin
                seen++;
                if (bus.mem_address != 15'd19199) errs++;
            end
            tick();
        end
        chk("oor_writes", seen, 1);
        chk("oor_addr_errs", errs, 0);
        chk("oor_drop", bus.DroppedCount, 2);

        // Clear flushes queue, full-screen fill
        do_reset();
        bus.mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setpix(1, 40 + i, 7, 12'hFFF);
            tick();
        end
        bus.ClearGo     = 1'b1;
        bus.ClearColour = 12'h00F;
        setpix(1, 1, 1, 12'hEEE);
        tick();
        bus.ClearGo = 1'b0;
        setpix(0, 0, 0, 12'h000);
        chk("clr_drop", bus.DroppedCount, 1);
        chk("clr_full", bus.Full, 1);
        bus.mem_grant = 1'b1;
        nw   = 0;
        errs = 0;
        for (int i = 0; i < 19400; i++) begin
            tick();
            if (bus.mem_wren) begin
                if (bus.mem_address != 15'(nw) || bus.mem_data != 12'h00F) errs++;
                nw++;
            end
            if (!bus.Busy) break;
        end
        chk("clr_count", nw, 19200);
        chk("clr_seq_errs", errs, 0);
        chk("clr_busy_done", bus.Busy, 0);

        // Clear with toggling grant, reset at address 5000
        do_reset();
        bus.mem_grant   = 1'b0;
        bus.ClearGo     = 1'b1;
        bus.ClearColour = 12'h0A5;
        setpix(1, 2, 2, 12'h123);
        tick();
        bus.ClearGo = 1'b0;
        setpix(0, 0, 0, 12'h000);
        nw   = 0;
        errs = 0;
        hit  = 1'b0;
        for (int i = 0; i < 12000 && !hit; i++) begin
            g = (i % 2 == 0);
            bus.mem_grant = g;
            tick();
            if (bus.mem_wren !== g) errs++;
            if (bus.mem_wren) begin
                if (bus.mem_address != 15'(nw) || bus.mem_data != 12'h0A5) errs++;
                nw++;
                if (bus.mem_address == 15'd5000) hit = 1'b1;
            end
        end
        chk("tog_reached_5000", hit, 1);
        chk("tog_errs", errs, 0);
        bus.mem_grant = 1'b1;
        do_reset();
        chk("abort_wren", bus.mem_wren, 0);
        chk("abort_drop", bus.DroppedCount, 0);
        chk("abort_full", bus.Full, 0);
        chk("abort_busy", bus.Busy, 0);
        setpix(1, 20, 3, 12'h321);
        tick();
        setpix(0, 0, 0, 12'h000);
        chk("post_abort_t1", bus.mem_wren, 0);
        tick();
        chk("post_abort_wren", bus.mem_wren, 1);
        chk("post_abort_addr", bus.mem_address, 500);
        chk("post_abort_data", bus.mem_data, 12'h321);

        // Drop counter saturation
        do_reset();
        bus.mem_grant = 1'b0;
        for (int i = 0; i < 316; i++) begin
            setpix(1, i % 160, 0, 12'h0F0);
            tick();
        end
        setpix(0, 0, 0, 12'h000);
        chk("sat_drop", bus.DroppedCount, 255);
        bus.mem_grant = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            setpix(($urandom % 4) != 0, $urandom_range(0, 175), $urandom_range(0, 127), 12'($urandom));
            bus.mem_grant = ($urandom % 3) != 0;
            tick();
        end
        setpix(0, 0, 0, 12'h000);
        bus.mem_grant = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("rand_idle", bus.Busy, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
